// File: rtl/noc_pkg.sv
// noc_pkg: shared flit layout, port indices and output-port FSM states
package noc_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int HEAD_BIT = DEF_DATA_W + 1;
  localparam int TAIL_BIT = DEF_DATA_W;
  typedef logic [DEF_DATA_W+1:0] flit_t;
  typedef enum logic [2:0] {P_N, P_S, P_W, P_E, P_L} port_e;
  typedef enum logic [1:0] {IDLE, XFER, ROTATE} out_state_e;
endpackage

// File: rtl/n_out_flit_reg.sv
// n_out_flit_reg: single-entry valid/ready output register for the north link
module n_out_flit_reg #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] data,
  input  logic         n_ready_i,
  output logic         load,
  output logic [W-1:0] n_flit_o,
  output logic         n_valid_o
);
  assign load = !n_valid_o || n_ready_i;
  always_ff @(posedge clk) begin
    if (reset) begin
      n_valid_o <= 1'b0;
      n_flit_o  <= '0;
    end else if (load) begin
      n_valid_o <= push;
      if (push) n_flit_o <= data;
    end
  end
endmodule

// File: rtl/n_output_port_ctrl.sv
// n_output_port_ctrl: locks the north output to the RR winner for one packet and streams its flits
module n_output_port_ctrl
  import noc_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int MAX_PKT_FLITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rrp_n_priority_s_i,
  input  logic              rrp_n_priority_w_i,
  input  logic              rrp_n_priority_e_i,
  input  logic              rrp_n_priority_l_i,
  input  logic [DATA_W+1:0] s_flit_i,
  input  logic [DATA_W+1:0] w_flit_i,
  input  logic [DATA_W+1:0] e_flit_i,
  input  logic [DATA_W+1:0] l_flit_i,
  input  logic              s_valid_i,
  input  logic              w_valid_i,
  input  logic              e_valid_i,
  input  logic              l_valid_i,
  output logic              s_pop_o,
  output logic              w_pop_o,
  output logic              e_pop_o,
  output logic              l_pop_o,
  output logic [DATA_W+1:0] n_flit_o,
  output logic              n_valid_o,
  input  logic              n_ready_i,
  output logic              rr_register_change_order_o,
  output logic [3:0]        owner_o,
  output logic              protocol_err_o
);
  localparam int CW = $clog2(MAX_PKT_FLITS + 1);
  out_state_e state, state_nx;
  logic [3:0] grant, valid, cand, owner, sel, pop;
  logic [DATA_W+1:0] sel_flit;
  logic [CW-1:0] cnt, cnt_inc;
  logic load, sel_valid, head, tail, last, multi, pop_any, err_set;
  assign grant = {rrp_n_priority_s_i, rrp_n_priority_w_i, rrp_n_priority_e_i, rrp_n_priority_l_i};
  assign valid = {s_valid_i, w_valid_i, e_valid_i, l_valid_i};
  assign cand = grant[3] ? 4'b1000 : grant[2] ? 4'b0100 : grant[1] ? 4'b0010 : {3'b000, grant[0]};
  assign multi = |(grant & (grant - 4'd1));
  assign sel = state == IDLE ? cand : state == XFER ? owner : 4'b0000;
  assign sel_flit = sel[3] ? s_flit_i : sel[2] ? w_flit_i : sel[1] ? e_flit_i : l_flit_i;
  assign sel_valid = |(sel & valid);
  assign head = sel_flit[DATA_W+1];
  assign tail = sel_flit[DATA_W];
  assign cnt_inc = cnt + CW'(1);
  assign last = tail || cnt_inc == CW'(MAX_PKT_FLITS);
  assign {s_pop_o, w_pop_o, e_pop_o, l_pop_o} = pop;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == ROTATE ? IDLE : pop_any && last ? ROTATE : pop_any ? XFER : state;
  end
  always_comb begin
    pop_any = !reset && sel_valid && load && (state == XFER || head);
    pop = sel & {4{pop_any}};
    owner_o = state == XFER ? owner : 4'b0000;
    rr_register_change_order_o = state == ROTATE && !reset;
    err_set = (state == IDLE && (multi || (sel_valid && !head)))
      || (pop_any && ((state == XFER && head) || (!tail && cnt_inc == CW'(MAX_PKT_FLITS))));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= '0;
      cnt <= '0;
      protocol_err_o <= 1'b0;
    end else begin
      if (state == IDLE && pop_any) owner <= cand;
      if (state == ROTATE) cnt <= '0;
      else if (pop_any) cnt <= cnt_inc;
      if (err_set) protocol_err_o <= 1'b1;
    end
  end
  n_out_flit_reg #(.W(DATA_W + 2)) u_out (
    .clk(clk),
    .reset(reset),
    .push(pop_any),
    .data(sel_flit),
    .n_ready_i(n_ready_i),
    .load(load),
    .n_flit_o(n_flit_o),
    .n_valid_o(n_valid_o)
  );
endmodule

// File: tb/tb_n_output_port_ctrl.sv
// tb_n_output_port_ctrl: directed self-checking bench for the north output port controller
module tb_n_output_port_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic rrp_n_priority_s_i, rrp_n_priority_w_i, rrp_n_priority_e_i, rrp_n_priority_l_i;
  logic [33:0] s_flit_i, w_flit_i, e_flit_i, l_flit_i;
  logic s_valid_i, w_valid_i, e_valid_i, l_valid_i;
  logic s_pop_o, w_pop_o, e_pop_o, l_pop_o;
  logic [33:0] n_flit_o;
  logic n_valid_o, n_ready_i, rr_register_change_order_o, protocol_err_o;
  logic [3:0] owner_o;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  n_output_port_ctrl #(.DATA_W(32), .MAX_PKT_FLITS(4)) dut (
    .clk(clk),
    .reset(reset),
    .rrp_n_priority_s_i(rrp_n_priority_s_i),
    .rrp_n_priority_w_i(rrp_n_priority_w_i),
    .rrp_n_priority_e_i(rrp_n_priority_e_i),
    .rrp_n_priority_l_i(rrp_n_priority_l_i),
    .s_flit_i(s_flit_i),
    .w_flit_i(w_flit_i),
    .e_flit_i(e_flit_i),
    .l_flit_i(l_flit_i),
    .s_valid_i(s_valid_i),
    .w_valid_i(w_valid_i),
    .e_valid_i(e_valid_i),
    .l_valid_i(l_valid_i),
    .s_pop_o(s_pop_o),
    .w_pop_o(w_pop_o),
    .e_pop_o(e_pop_o),
    .l_pop_o(l_pop_o),
    .n_flit_o(n_flit_o),
    .n_valid_o(n_valid_o),
    .n_ready_i(n_ready_i),
    .rr_register_change_order_o(rr_register_change_order_o),
    .owner_o(owner_o),
    .protocol_err_o(protocol_err_o)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [33:0] fl(input logic h, input logic t, input logic [31:0] d);
    return {h, t, d};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    {rrp_n_priority_s_i, rrp_n_priority_w_i, rrp_n_priority_e_i, rrp_n_priority_l_i} = 4'b0000;
    {s_valid_i, w_valid_i, e_valid_i, l_valid_i} = 4'b0000;
  endtask
  task automatic chk_pops(input string tag, input logic [3:0] exp);
    #1;
    chk(tag, {s_pop_o, w_pop_o, e_pop_o, l_pop_o}, exp);
  endtask
  initial begin
    reset = 1'b1;
    n_ready_i = 1'b1;
    idle_inputs();
    s_flit_i = '0; w_flit_i = '0; e_flit_i = '0; l_flit_i = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_owner", owner_o, 4'b0000);
    chk("rst_valid", n_valid_o, 1'b0);
    chk("rst_flit", n_flit_o, 34'h0);
    chk("rst_err", protocol_err_o, 1'b0);
    chk("rst_rot", rr_register_change_order_o, 1'b0);
    chk_pops("rst_pops", 4'b0000);
    // W three-flit packet
    rrp_n_priority_w_i = 1'b1; w_valid_i = 1'b1; w_flit_i = fl(1, 0, 32'hA1);
    chk_pops("w_pop_h", 4'b0100);
    tick();
    chk("w_flit_h", n_flit_o, fl(1, 0, 32'hA1));
    chk("w_valid_h", n_valid_o, 1'b1);
    chk("w_owner", owner_o, 4'b0100);
    w_flit_i = fl(0, 0, 32'hA2);
    chk_pops("w_pop_b", 4'b0100);
    tick();
    chk("w_flit_b", n_flit_o, fl(0, 0, 32'hA2));
    chk("w_rot_b", rr_register_change_order_o, 1'b0);
    w_flit_i = fl(0, 1, 32'hA3);
    chk_pops("w_pop_t", 4'b0100);
    tick();
    chk("w_flit_t", n_flit_o, fl(0, 1, 32'hA3));
    chk("w_rot", rr_register_change_order_o, 1'b1);
    chk("w_owner_rot", owner_o, 4'b0000);
    idle_inputs();
    chk_pops("w_pop_rot", 4'b0000);
    tick();
    chk("w_rot_end", rr_register_change_order_o, 1'b0);
    chk("w_drain", n_valid_o, 1'b0);
    // single-flit S packet
    rrp_n_priority_s_i = 1'b1; s_valid_i = 1'b1; s_flit_i = fl(1, 1, 32'h55);
    chk_pops("s_pop", 4'b1000);
    tick();
    chk("s_flit", n_flit_o, fl(1, 1, 32'h55));
    chk("s_rot", rr_register_change_order_o, 1'b1);
    idle_inputs();
    tick();
    chk("s_rot_end", rr_register_change_order_o, 1'b0);
    // grant moves to E while W owns the port
    rrp_n_priority_w_i = 1'b1; w_valid_i = 1'b1; w_flit_i = fl(1, 0, 32'hB1);
    chk_pops("sw_pop_h", 4'b0100);
    tick();
    rrp_n_priority_w_i = 1'b0; rrp_n_priority_e_i = 1'b1;
    e_valid_i = 1'b1; e_flit_i = fl(1, 1, 32'hC1);
    w_flit_i = fl(0, 0, 32'hB2);
    chk_pops("sw_pop_b", 4'b0100);
    tick();
    chk("sw_flit_b", n_flit_o, fl(0, 0, 32'hB2));
    w_flit_i = fl(0, 1, 32'hB3);
    chk_pops("sw_pop_t", 4'b0100);
    tick();
    chk("sw_rot", rr_register_change_order_o, 1'b1);
    w_valid_i = 1'b0;
    chk_pops("sw_pop_rot", 4'b0000);
    tick();
    chk_pops("sw_e_pop", 4'b0010);
    tick();
    chk("sw_e_flit", n_flit_o, fl(1, 1, 32'hC1));
    chk("sw_e_rot", rr_register_change_order_o, 1'b1);
    chk("sw_err", protocol_err_o, 1'b0);
    idle_inputs();
    tick();
    // backpressure during body flit
    rrp_n_priority_w_i = 1'b1; w_valid_i = 1'b1; w_flit_i = fl(1, 0, 32'hD1);
    tick();
    w_flit_i = fl(0, 0, 32'hD2);
    chk_pops("bp_pop_b", 4'b0100);
    tick();
    n_ready_i = 1'b0;
    w_flit_i = fl(0, 1, 32'hD3);
    for (int i = 0; i < 4; i++) begin
      chk_pops("bp_stall_pop", 4'b0000);
      tick();
      chk("bp_stall_flit", n_flit_o, fl(0, 0, 32'hD2));
      chk("bp_stall_valid", n_valid_o, 1'b1);
    end
    n_ready_i = 1'b1;
    chk_pops("bp_resume_pop", 4'b0100);
    tick();
    chk("bp_resume_flit", n_flit_o, fl(0, 1, 32'hD3));
    chk("bp_rot", rr_register_change_order_o, 1'b1);
    idle_inputs();
    tick();
    // L exceeds MAX_PKT_FLITS=4 without tail
    rrp_n_priority_l_i = 1'b1; l_valid_i = 1'b1; l_flit_i = fl(1, 0, 32'hE0);
    chk_pops("max_pop_h", 4'b0001);
    tick();
    for (int i = 1; i < 4; i++) begin
      l_flit_i = fl(0, 0, 32'hE0 + 32'(i));
      chk_pops("max_pop_b", 4'b0001);
      tick();
      chk("max_flit", n_flit_o, fl(0, 0, 32'hE0 + 32'(i)));
    end
    l_flit_i = fl(0, 0, 32'hE4);
    chk("max_err", protocol_err_o, 1'b1);
    chk("max_rot", rr_register_change_order_o, 1'b1);
    chk_pops("max_pop_rot", 4'b0000);
    tick();
    chk_pops("max_idle_nohead", 4'b0000);
    idle_inputs();
    // reset in XFER
    rrp_n_priority_w_i = 1'b1; w_valid_i = 1'b1; w_flit_i = fl(1, 0, 32'hF1);
    tick();
    chk("rx_owner", owner_o, 4'b0100);
    reset = 1'b1;
    w_flit_i = fl(0, 0, 32'hF2);
    chk_pops("rx_pop_in_reset", 4'b0000);
    chk("rx_rot_in_reset", rr_register_change_order_o, 1'b0);
    tick();
    reset = 1'b0;
    chk("rx_owner0", owner_o, 4'b0000);
    chk("rx_valid0", n_valid_o, 1'b0);
    chk("rx_flit0", n_flit_o, 34'h0);
    chk("rx_err0", protocol_err_o, 1'b0);
    w_flit_i = fl(1, 1, 32'hF9);
    chk_pops("rx_pop_new", 4'b0100);
    tick();
    chk("rx_flit_new", n_flit_o, fl(1, 1, 32'hF9));
    chk("rx_rot_new", rr_register_change_order_o, 1'b1);
    idle_inputs();
    tick();
    // multiple grant bits: S wins and error is flagged
    rrp_n_priority_s_i = 1'b1; rrp_n_priority_e_i = 1'b1;
    s_valid_i = 1'b1; e_valid_i = 1'b1;
    s_flit_i = fl(1, 1, 32'h77); e_flit_i = fl(1, 1, 32'h88);
    chk_pops("mg_pop", 4'b1000);
    tick();
    chk("mg_flit", n_flit_o, fl(1, 1, 32'h77));
    chk("mg_err", protocol_err_o, 1'b1);
    idle_inputs();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/n_output_port_ctrl.md
Name: n_output_port_ctrl

Overview:
- Downstream consumer of the north-output round-robin processor.
- Latches the one-hot grant it produces and locks the north output to the winning input (S/W/E/L) for a whole packet.
- Streams that input's flits through a one-entry output register with valid/ready handshake to the north link.
- Pulses rr_register_change_order_o once per completed packet so the RR registers rotate before the next arbitration.

Parameters:
- DATA_W, 32, payload bits per flit; flit = {head, tail, data}, width DATA_W+2.
- MAX_PKT_FLITS, 16, packet length limit including head; exceeding it forces release.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- rrp_n_priority_s_i / _w_i / _e_i / _l_i  input  1 each  grant from RR processor (combinational, expected one-hot)
- s_flit_i / w_flit_i / e_flit_i / l_flit_i  input  DATA_W+2 each  head flit of each input buffer; bit DATA_W+1 = head, bit DATA_W = tail
- s_valid_i / w_valid_i / e_valid_i / l_valid_i  input  1 each  input buffer non-empty
- s_pop_o / w_pop_o / e_pop_o / l_pop_o  output  1 each  dequeue strobe to the input buffer
- n_flit_o  output  DATA_W+2  north link flit
- n_valid_o  output  1  north link valid
- n_ready_i  input  1  north link ready
- rr_register_change_order_i... none; output is rr_register_change_order_o  output  1  one-cycle rotate pulse to the RR registers
- owner_o  output  4  one-hot {s,w,e,l} current owner; 0 when idle
- protocol_err_o  output  1  sticky error flag

Behaviour:
- Reset values: state IDLE, owner_o=0, n_valid_o=0, n_flit_o=0, all pop_o=0, rr_register_change_order_o=0, protocol_err_o=0, flit counter=0.
- Reset mid-packet: the in-flight output flit is dropped; no pop and no rotate pulse are issued.
- load = !n_valid_o || n_ready_i. The output register loads on load; when n_valid_o && !n_ready_i, n_flit_o holds stable.

State IDLE:
- Candidate = granted input, resolved with fixed priority s>w>e>l if more than one grant bit is set. Multiple grant bits also set protocol_err_o.
- If the candidate's valid_i=1, its head bit=1, and load=1:
  - pop_o=1 that cycle, flit loads, owner latched, counter=1.
  - Next state: ROTATE if the tail bit is also set (single-flit packet), else XFER.
- If the candidate is valid with head=0: no pop, set protocol_err_o, stay in IDLE.
- With no grant or no valid: stay in IDLE.

State XFER:
- Grant inputs are ignored.
- pop_o[owner] = valid_i[owner] && load; on a pop the flit loads and the counter increments.
- Popped flit with tail=1 -> ROTATE.
- Popped flit with head=1 (mid-packet): forwarded anyway, protocol_err_o set.
- Counter reaches MAX_PKT_FLITS with the last pop lacking tail -> protocol_err_o set, go to ROTATE (forced release).
- Owner stall (valid_i=0): wait indefinitely, no pop.

State ROTATE:
- Exactly one cycle with rr_register_change_order_o=1, owner_o=0, no pops.
- The output register continues to drain.
- Next state IDLE, so the next arbitration sees the rotated order.

Timing and invariants:
- Latency: grant+valid head in cycle t -> n_valid_o=1 with that flit at t+1.
- Sustained throughput: 1 flit/cycle when n_ready_i=1.
- Minimum packet-to-packet gap: 1 bubble cycle (ROTATE).
- At most one pop_o asserted per cycle, and only the owner's, except the IDLE accept pop.

Decomposition:
- noc_pkg holds:
  - flit_t typedef and HEAD_BIT/TAIL_BIT positions;
  - port index enum {P_N, P_S, P_W, P_E, P_L};
  - out_state_e {IDLE, XFER, ROTATE};
  - DATA_W default.
- One sub-module, n_out_flit_reg: a single-entry valid/ready output register taking load/data and driving n_flit_o/n_valid_o.

Test Plan:
- Grant W, w_valid_i=1, 3-flit packet (H, body, T), n_ready_i=1 -> w_pop_o high 3 consecutive cycles; n_valid_o flits H,B,T at t+1..t+3; change_order pulse exactly 1 cycle after T pops; owner_o=0100 during transfer.
- Single-flit S packet (head=tail=1) -> one s_pop_o, ROTATE next cycle, change_order=1 for 1 cycle, back to IDLE.
- Mid-packet grant switches to E while W owns -> e_pop_o never asserts until W tail, then E accepted after ROTATE.
- n_ready_i=0 for 4 cycles during body flit -> n_flit_o stable, no pops; resumes 1 flit/cycle on n_ready_i=1.
- MAX_PKT_FLITS=4, L sends 5 flits without tail -> 4 pops, protocol_err_o=1, forced ROTATE.
- Reset asserted in XFER -> next cycle all outputs at reset values, protocol_err_o cleared, new head accepted normally.
